// File: rtl/fpmul_out_buffer.sv
// Output buffer for the pipelined FPmul: tracks operand validity, classifies and queues results.
// Optional build macro FPBUF_STATS_EN adds saturating pop / NaN-pop counters.
module fpmul_out_buffer #(
  parameter int MUL_LAT = 4,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   FP_Z,
  output logic [31:0]   out_data,
  output logic [3:0]    out_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          full,
  output logic [AW:0]   occupancy,
  output logic          overflow_err
`ifdef FPBUF_STATS_EN
  ,
  output logic [15:0]   stat_out_cnt,
  output logic [15:0]   stat_nan_cnt
`endif
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [MUL_LAT-1:0] vld_sr_reg;
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW-1:0]      rd_ptr_next;
  logic [AW:0]        occupancy_reg;
  logic [AW:0]        occupancy_next;
  logic [35:0]        head_reg;
  logic               overflow_reg;
  logic [35:0]        mem [DEPTH];

  logic        cap;
  logic        push;
  logic        pop;
  logic [7:0]  z_exp;
  logic [22:0] z_man;
  logic [3:0]  z_flags;
  logic [35:0] entry;

  // Validity delay line mirrors the FPmul pipeline depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_reg <= '0;
    end else begin
      vld_sr_reg[0] <= in_valid;
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_sr_reg[k] <= vld_sr_reg[k-1];
      end
    end
  end

  assign cap = vld_sr_reg[MUL_LAT-1];

  assign z_exp   = FP_Z[30:23];
  assign z_man   = FP_Z[22:0];
  assign z_flags = {(z_exp == 8'hFF) && (z_man != 23'd0),
                    (z_exp == 8'hFF) && (z_man == 23'd0),
                    (z_exp == 8'h00) && (z_man == 23'd0),
                    (z_exp == 8'h00) && (z_man != 23'd0)};
  assign entry   = {z_flags, FP_Z};

  assign out_valid = (occupancy_reg != '0);
  assign full      = (occupancy_reg == DEPTH_CNT);
  assign pop       = out_valid && out_ready;
  assign push      = cap && (!full || pop);

  assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_comb begin
    occupancy_next = occupancy_reg;
    if (push && !pop) begin
      occupancy_next = occupancy_reg + (AW+1)'(1);
    end else if (pop && !push) begin
      occupancy_next = occupancy_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  // Head register: registered read of the next head slot, with a write-through
  // path when the entry being pushed becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (occupancy_next == '0) begin
      head_reg <= '0;
    end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= entry;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occupancy_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg    <= rd_ptr_next;
      occupancy_reg <= occupancy_next;
      if (cap && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign out_data     = head_reg[31:0];
  assign out_flags    = head_reg[35:32];
  assign occupancy    = occupancy_reg;
  assign overflow_err = overflow_reg;

`ifdef FPBUF_STATS_EN
  logic [15:0] stat_out_cnt_reg;
  logic [15:0] stat_nan_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_out_cnt_reg <= '0;
      stat_nan_cnt_reg <= '0;
    end else if (pop) begin
      if (stat_out_cnt_reg != 16'hFFFF) begin
        stat_out_cnt_reg <= stat_out_cnt_reg + 16'd1;
      end
      if (head_reg[35] && (stat_nan_cnt_reg != 16'hFFFF)) begin
        stat_nan_cnt_reg <= stat_nan_cnt_reg + 16'd1;
      end
    end
  end

  assign stat_out_cnt = stat_out_cnt_reg;
  assign stat_nan_cnt = stat_nan_cnt_reg;
`endif

endmodule
